// File: rtl/sram_arb_pkg.sv
// Shared constants and helpers for the two-port SRAM arbiter.
package sram_arb_pkg;

   localparam logic OWNER_A = 1'b0;
   localparam logic OWNER_B = 1'b1;

   function automatic int clog2(input int value);
      int w;
      w = 0;
      while ((1 << w) < value) w++;
      return w;
   endfunction

endpackage

// File: rtl/sram_tag_fifo.sv
// In-order owner-tag FIFO; head is valid combinationally while non-empty.
module sram_tag_fifo
   import sram_arb_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int PW = clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [PW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (PW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign head    = mem[rd_ptr];
   // A pop in the same cycle frees the slot, so a push into a full FIFO is legal then.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/sram_arbiter.sv
// Two-requester round-robin arbiter in front of one SRAM client port,
// with read beats routed back to their issuer through an owner-tag FIFO.
module sram_arbiter
   import sram_arb_pkg::*;
#(
   parameter int ADDR_WIDTH = 19,
   parameter int DATA_WIDTH = 8,
   parameter int TAG_DEPTH  = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  a_req,
   output logic                  a_ack,
   input  logic [ADDR_WIDTH-1:0] a_addr,
   input  logic                  a_rh_wl,
   input  logic [DATA_WIDTH-1:0] a_data_w,
   output logic [DATA_WIDTH-1:0] a_data_r,
   output logic                  a_data_r_en,
   input  logic                  b_req,
   output logic                  b_ack,
   input  logic [ADDR_WIDTH-1:0] b_addr,
   input  logic                  b_rh_wl,
   input  logic [DATA_WIDTH-1:0] b_data_w,
   output logic [DATA_WIDTH-1:0] b_data_r,
   output logic                  b_data_r_en,
   output logic                  sram_req,
   input  logic                  sram_ack,
   output logic [ADDR_WIDTH-1:0] sram_addr,
   output logic                  sram_rh_wl,
   output logic [DATA_WIDTH-1:0] sram_data_w,
   input  logic [DATA_WIDTH-1:0] sram_data_r,
   input  logic                  sram_data_r_en,
   output logic                  err
);

   logic prio;
   logic win_b;
   logic a_elig;
   logic b_elig;
   logic read_room;
   logic xfer;
   logic pop;
   logic tag_head;
   logic tag_full;
   logic tag_empty;

   // A returning beat frees a tag slot in the same cycle.
   assign read_room = !tag_full || (sram_data_r_en && !tag_empty);
   assign a_elig    = !reset && a_req && (!a_rh_wl || read_room);
   assign b_elig    = !reset && b_req && (!b_rh_wl || read_room);
   assign win_b     = b_elig && (!a_elig || (prio == OWNER_B));

   assign sram_req    = a_elig || b_elig;
   assign sram_addr   = win_b ? b_addr   : a_addr;
   assign sram_rh_wl  = win_b ? b_rh_wl  : a_rh_wl;
   assign sram_data_w = win_b ? b_data_w : a_data_w;

   assign xfer  = sram_req && sram_ack;
   assign a_ack = xfer && !win_b;
   assign b_ack = xfer && win_b;

   assign pop         = sram_data_r_en && !tag_empty && !reset;
   assign a_data_r_en = pop && (tag_head == OWNER_A);
   assign b_data_r_en = pop && (tag_head == OWNER_B);
   assign a_data_r    = sram_data_r;
   assign b_data_r    = sram_data_r;

   sram_tag_fifo #(
      .DEPTH (TAG_DEPTH),
      .WIDTH (1)
   ) u_tag_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (xfer && sram_rh_wl),
      .push_data (win_b),
      .pop       (pop),
      .head      (tag_head),
      .full      (tag_full),
      .empty     (tag_empty)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         prio <= OWNER_A;
         err  <= 1'b0;
      end else begin
         if (xfer) prio <= win_b ? OWNER_A : OWNER_B;
         if (sram_data_r_en && tag_empty) err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: queue-based reference model checked every cycle,
// randomized requesters/controller, plus directed scenarios with literal expectations.
module tb_sram_arbiter;
   import sram_arb_pkg::*;

   localparam int AW = 19;
   localparam int DW = 8;
   localparam int TD = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          a_req, a_ack, a_rh_wl, a_data_r_en;
   logic [AW-1:0] a_addr;
   logic [DW-1:0] a_data_w, a_data_r;
   logic          b_req, b_ack, b_rh_wl, b_data_r_en;
   logic [AW-1:0] b_addr;
   logic [DW-1:0] b_data_w, b_data_r;
   logic          sram_req, sram_ack, sram_rh_wl, sram_data_r_en, err;
   logic [AW-1:0] sram_addr;
   logic [DW-1:0] sram_data_w, sram_data_r;

   always #5 clk = ~clk;

   sram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_DEPTH(TD)) dut (
      .clk(clk), .reset(reset),
      .a_req(a_req), .a_ack(a_ack), .a_addr(a_addr), .a_rh_wl(a_rh_wl),
      .a_data_w(a_data_w), .a_data_r(a_data_r), .a_data_r_en(a_data_r_en),
      .b_req(b_req), .b_ack(b_ack), .b_addr(b_addr), .b_rh_wl(b_rh_wl),
      .b_data_w(b_data_w), .b_data_r(b_data_r), .b_data_r_en(b_data_r_en),
      .sram_req(sram_req), .sram_ack(sram_ack), .sram_addr(sram_addr),
      .sram_rh_wl(sram_rh_wl), .sram_data_w(sram_data_w),
      .sram_data_r(sram_data_r), .sram_data_r_en(sram_data_r_en), .err(err)
   );

   int checks = 0;
   int passes = 0;
   int cycle  = 0;

   // reference model: priority side, sticky error, owner queue of outstanding reads
   bit m_prio = 1'b0;
   bit m_err  = 1'b0;
   bit m_tags[$];

   // random-phase controller: beat due cycles and their data, plus a small backing store
   bit            rnd_mode = 1'b0;
   bit            acc_a = 1'b0, acc_b = 1'b0;
   int            ret_due[$];
   logic [DW-1:0] ret_data[$];
   int            last_due = 0;
   logic [DW-1:0] mem [16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
   endtask

   always @(negedge clk) begin
      bit ea, eb, wb, xfer, rd_ok, pop_ok, exp_ra, exp_rb;
      int lat, due;
      rd_ok  = (m_tags.size() < TD) || sram_data_r_en;
      ea     = !reset && a_req && (!a_rh_wl || rd_ok);
      eb     = !reset && b_req && (!b_rh_wl || rd_ok);
      wb     = eb && (!ea || m_prio);
      xfer   = (ea || eb) && sram_ack;
      pop_ok = !reset && sram_data_r_en && (m_tags.size() > 0);
      exp_ra = pop_ok && (m_tags[0] == OWNER_A);
      exp_rb = pop_ok && (m_tags[0] == OWNER_B);
      check("sram_req", sram_req, ea || eb);
      check("a_ack", a_ack, xfer && !wb);
      check("b_ack", b_ack, xfer && wb);
      check("sram_addr", sram_addr, wb ? b_addr : a_addr);
      check("sram_rh_wl", sram_rh_wl, wb ? b_rh_wl : a_rh_wl);
      check("sram_data_w", sram_data_w, wb ? b_data_w : a_data_w);
      check("a_data_r_en", a_data_r_en, exp_ra);
      check("b_data_r_en", b_data_r_en, exp_rb);
      check("a_data_r", a_data_r, sram_data_r);
      check("b_data_r", b_data_r, sram_data_r);
      check("err", err, m_err);
      acc_a = xfer && !wb;
      acc_b = xfer && wb;
      if (reset) begin
         m_prio = OWNER_A;
         m_err  = 1'b0;
         m_tags.delete();
      end else begin
         if (sram_data_r_en) begin
            if (m_tags.size() > 0) void'(m_tags.pop_front());
            else m_err = 1'b1;
         end
         if (xfer) begin
            m_prio = !wb;
            if (wb ? b_rh_wl : a_rh_wl) begin
               m_tags.push_back(wb);
               if (rnd_mode) begin
                  lat = $urandom_range(1, 8);
                  due = (cycle + lat > last_due + 1) ? cycle + lat : last_due + 1;
                  last_due = due;
                  ret_due.push_back(due);
                  ret_data.push_back(mem[(wb ? b_addr[3:0] : a_addr[3:0])]);
               end
            end else if (rnd_mode) begin
               mem[(wb ? b_addr[3:0] : a_addr[3:0])] = wb ? b_data_w : a_data_w;
            end
         end
      end
      cycle++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic at_neg();
      @(negedge clk);
      #1;
   endtask

   task automatic idle();
      a_req = 0; a_rh_wl = 0; a_addr = '0; a_data_w = '0;
      b_req = 0; b_rh_wl = 0; b_addr = '0; b_data_w = '0;
      sram_ack = 0; sram_data_r = '0; sram_data_r_en = 0;
   endtask

   task automatic do_reset();
      tick();
      idle();
      reset = 1;
      tick();
      reset = 0;
   endtask

   task automatic rnd_drive(input bit allow_new);
      if (acc_a) a_req = 0;
      if (acc_b) b_req = 0;
      if (!a_req && allow_new && ($urandom_range(0, 1) == 1)) begin
         a_req = 1; a_rh_wl = 1'($urandom_range(0, 1));
         a_addr = AW'($urandom_range(0, 15)); a_data_w = DW'($urandom);
      end
      if (!b_req && allow_new && ($urandom_range(0, 1) == 1)) begin
         b_req = 1; b_rh_wl = 1'($urandom_range(0, 1));
         b_addr = AW'($urandom_range(0, 15)); b_data_w = DW'($urandom);
      end
      sram_ack = ($urandom_range(0, 3) != 0);
      if (ret_due.size() > 0 && ret_due[0] == cycle) begin
         void'(ret_due.pop_front());
         sram_data_r_en = 1;
         sram_data_r    = ret_data.pop_front();
      end else begin
         sram_data_r_en = 0;
         sram_data_r    = DW'($urandom);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish, got running expected finished");
      $fatal(1);
   end

   initial begin
      int ack_a[5] = '{1, 0, 1, 0, 0};
      int ack_b[5] = '{0, 1, 0, 1, 0};
      int ren_a[5] = '{0, 1, 0, 1, 0};
      int ren_b[5] = '{0, 0, 1, 0, 1};
      int vr_a[6]  = '{1, 0, 1, 0, 0, 0};
      int vr_b[6]  = '{0, 1, 0, 0, 0, 0};
      int vd[6]    = '{0, 0, 0, 'h10, 'h20, 'h30};
      int ve_a[6]  = '{0, 0, 0, 1, 0, 1};
      int ve_b[6]  = '{0, 0, 0, 0, 1, 0};
      int guard;

      for (int i = 0; i < 16; i++) mem[i] = DW'(i * 7);
      idle();
      reset = 1;
      a_req = 1; a_rh_wl = 1; b_req = 1; sram_ack = 1;
      at_neg();
      check("reset_sram_req", sram_req, 0);
      check("reset_a_ack", a_ack, 0);
      check("reset_b_ack", b_ack, 0);
      do_reset();
      check("post_reset_err", err, 0);

      // single-port write, then both write: B must win next
      a_req = 1; a_rh_wl = 0; a_addr = 19'h00010; a_data_w = 8'h5A; sram_ack = 1;
      at_neg();
      check("wr_addr", sram_addr, 19'h00010);
      check("wr_data", sram_data_w, 8'h5A);
      check("wr_a_ack", a_ack, 1);
      check("wr_b_ack", b_ack, 0);
      tick();
      b_req = 1; b_rh_wl = 0; b_addr = 19'h00020; b_data_w = 8'h11;
      at_neg();
      check("prio_b_wins", b_ack, 1);
      check("prio_a_loses", a_ack, 0);

      // contention reads with one-cycle return
      do_reset();
      for (int i = 0; i < 5; i++) begin
         a_req = (i < 4); a_rh_wl = 1; a_addr = 19'h1;
         b_req = (i < 4); b_rh_wl = 1; b_addr = 19'h2;
         sram_ack = 1;
         sram_data_r_en = (i > 0);
         sram_data_r = DW'(i);
         at_neg();
         check("cont_a_ack", a_ack, ack_a[i]);
         check("cont_b_ack", b_ack, ack_b[i]);
         check("cont_a_ren", a_data_r_en, ren_a[i]);
         check("cont_b_ren", b_data_r_en, ren_b[i]);
         tick();
      end

      // three-cycle return latency
      do_reset();
      for (int i = 0; i < 6; i++) begin
         a_req = vr_a[i][0]; a_rh_wl = 1; a_addr = (i == 0) ? 19'h10 : 19'h30;
         b_req = vr_b[i][0]; b_rh_wl = 1; b_addr = 19'h20;
         sram_ack = 1;
         sram_data_r_en = (vd[i] != 0);
         sram_data_r = DW'(vd[i]);
         at_neg();
         check("lat_a_ren", a_data_r_en, ve_a[i]);
         check("lat_b_ren", b_data_r_en, ve_b[i]);
         if (ve_a[i] == 1) check("lat_a_data", a_data_r, vd[i]);
         if (ve_b[i] == 1) check("lat_b_data", b_data_r, vd[i]);
         tick();
      end

      // tag FIFO full
      do_reset();
      a_req = 1; a_rh_wl = 1; a_addr = 19'h3; sram_ack = 1;
      for (int i = 0; i < 4; i++) begin
         at_neg();
         check("fill_a_ack", a_ack, 1);
         tick();
      end
      b_req = 1; b_rh_wl = 0; b_addr = 19'h4; b_data_w = 8'h77;
      at_neg();
      check("full_a_ack", a_ack, 0);
      check("full_b_ack", b_ack, 1);
      tick();
      b_req = 0; sram_data_r_en = 1; sram_data_r = 8'hC1;
      at_neg();
      check("full_pop_a_ack", a_ack, 1);
      check("full_pop_a_ren", a_data_r_en, 1);
      tick();
      sram_data_r_en = 0;
      at_neg();
      check("still_full_a_ack", a_ack, 0);
      check("still_full_req", sram_req, 0);
      tick();
      a_req = 0;
      for (int i = 0; i < 4; i++) begin
         sram_data_r_en = 1;
         at_neg();
         check("drain_a_ren", a_data_r_en, 1);
         tick();
      end
      sram_data_r_en = 0;
      at_neg();
      check("drain_err", err, 0);

      // spurious beat on empty FIFO
      do_reset();
      sram_data_r_en = 1;
      at_neg();
      check("spur_a_ren", a_data_r_en, 0);
      check("spur_b_ren", b_data_r_en, 0);
      check("spur_err_before", err, 0);
      tick();
      sram_data_r_en = 0;
      at_neg();
      check("spur_err_set", err, 1);
      tick(); tick();
      at_neg();
      check("spur_err_held", err, 1);

      // reset with reads in flight
      do_reset();
      check("rst_clears_err", err, 0);
      a_req = 1; a_rh_wl = 1; b_req = 1; b_rh_wl = 1; sram_ack = 1;
      tick(); tick();
      reset = 1;
      at_neg();
      check("mid_rst_req", sram_req, 0);
      check("mid_rst_a_ack", a_ack, 0);
      check("mid_rst_b_ack", b_ack, 0);
      tick();
      reset = 0; a_rh_wl = 0; b_rh_wl = 0;
      at_neg();
      check("mid_rst_prio_a", a_ack, 1);
      tick();
      a_req = 0; b_req = 0; sram_data_r_en = 1;
      at_neg();
      check("late_beat_a_ren", a_data_r_en, 0);
      check("late_beat_b_ren", b_data_r_en, 0);
      tick();
      sram_data_r_en = 0;
      at_neg();
      check("late_beat_err", err, 1);

      // randomized traffic
      do_reset();
      ret_due.delete();
      ret_data.delete();
      last_due = cycle;
      rnd_mode = 1;
      for (int k = 0; k < 3000; k++) begin
         tick();
         rnd_drive(1'b1);
      end
      guard = 0;
      while ((a_req || b_req || ret_due.size() > 0) && guard < 400) begin
         tick();
         rnd_drive(1'b0);
         guard++;
      end
      check("drain_done", (a_req || b_req || ret_due.size() > 0), 0);
      tick();
      idle();
      at_neg();
      check("rnd_err_clear", err, 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Two-requester arbiter in front of a single SRAM/BRAM client port. Typical users are port A (CPU) and port B (video/DMA fetch).
- Selects one requester per cycle with alternating round-robin priority.
- Forwards the winner's address, direction and write data to the memory controller.
- Routes each returned read beat back to the requester that issued it, using an in-order owner-tag FIFO. This supports controllers with any fixed or variable read latency.

Parameters:
- ADDR_WIDTH, 19, address width on all ports.
- DATA_WIDTH, 8, data width on all ports.
- TAG_DEPTH, 4, maximum outstanding reads; power of two, ≥2.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- reset  in  1  synchronous, active-high reset.
- a_req  in  1  port A transfer request; held with fields stable until a_ack.
- a_ack  out  1  port A transfer accepted this cycle.
- a_addr  in  ADDR_WIDTH  port A address.
- a_rh_wl  in  1  port A direction: 1 = read, 0 = write.
- a_data_w  in  DATA_WIDTH  port A write data.
- a_data_r  out  DATA_WIDTH  port A read data (broadcast copy of sram_data_r).
- a_data_r_en  out  1  port A read data valid.
- b_req, b_ack, b_addr, b_rh_wl, b_data_w, b_data_r, b_data_r_en  same directions, widths and meanings as port A, for port B.
- sram_req  out  1  downstream request.
- sram_ack  in  1  downstream accept; may depend combinationally on sram_req.
- sram_addr  out  ADDR_WIDTH  downstream address.
- sram_rh_wl  out  1  downstream direction.
- sram_data_w  out  DATA_WIDTH  downstream write data.
- sram_data_r  in  DATA_WIDTH  downstream read data.
- sram_data_r_en  in  1  downstream read data valid; read beats return in issue order.
- err  out  1  sticky error: a read beat arrived with no read outstanding.

Behaviour:
- Transfer: accepted in any cycle with sram_req && sram_ack. One accepted transfer per cycle at most.
- Eligibility:
  - A requester is eligible when its req = 1.
  - If it is requesting a read (rh_wl = 1), it is also required that the tag FIFO is not full.
  - Writes are never blocked by FIFO state.
- Selection (combinational):
  - If only one requester is eligible, it wins.
  - If both are eligible, the side indicated by the priority register prio wins.
  - sram_req = 1 when any requester is eligible; the addr, rh_wl and data_w muxes follow the winner.
  - When no requester is eligible, the muxes select A and sram_req = 0.
- Acks: winner_ack = sram_ack && sram_req && winner selected; the loser's ack = 0. Zero added latency on the request path.
- Priority update: on each accepted transfer, prio <= the non-winning side. No accepted transfer leaves prio unchanged.
- Tag FIFO:
  - On an accepted read, the owner id (0 = A, 1 = B) is pushed.
  - On sram_data_r_en = 1 with the FIFO non-empty, the head is popped and the matching x_data_r_en is pulsed for that same cycle. Read-return path is combinational, zero added latency.
  - Push and pop in the same cycle: both occur, count unchanged. This is permitted even when the FIFO is full (a pop frees the slot, so a read is eligible when full && sram_data_r_en).
  - Pointers wrap modulo TAG_DEPTH. Count spans 0..TAG_DEPTH.
- Empty-FIFO beat: sram_data_r_en = 1 with the FIFO empty → both x_data_r_en = 0, err <= 1 and err stays set until reset.
- Read data: a_data_r = b_data_r = sram_data_r at all times.
- Reset (synchronous):
  - State: prio <= A, FIFO emptied, err <= 0.
  - While reset = 1: sram_req = 0, a_ack = b_ack = 0, a_data_r_en = b_data_r_en = 0.
  - Reset mid-operation: outstanding tags are discarded. Beats returning after reset count as empty-FIFO beats and set err.
- Requester rule: after issuing a read, a requester may issue further reads without waiting for data, up to the FIFO limit shared by both ports.

Decomposition:
- Package sram_arb_pkg holds:
  - localparam OWNER_A = 1'b0, OWNER_B = 1'b1.
  - Function clog2 for FIFO pointer width.
- One sub-module: sram_tag_fifo.
  - Parameters: DEPTH, WIDTH = 1.
  - Ports: push, push_data, pop, head, full, empty, synchronous active-high reset.
  - The arbiter top holds prio, the muxes and err.

Test Plan:
- Single-port write: a_req = 1, a_rh_wl = 0, a_addr = 0x00010, a_data_w = 0x5A, sram_ack = 1 → in the same cycle, sram_addr = 0x00010, sram_data_w = 0x5A, a_ack = 1, b_ack = 0; prio becomes B.
- Contention: A and B both request reads (addresses 0x1, 0x2) for 4 cycles with sram_ack = 1 and 1-cycle read latency → grants A, B, A, B in turn; data_r_en pulses reach A, B, A, B one cycle after each grant.
- Variable latency: the controller returns each beat 3 cycles late. A reads 0x10, B reads 0x20, then A reads 0x30 → a_data_r_en, b_data_r_en, a_data_r_en in that order, with data 0x10/0x20/0x30 values as stored.
- FIFO full:
  - With TAG_DEPTH = 4, issue 4 reads with no returns, then A requests a read and B requests a write → a_ack = 0, b_ack = 1.
  - Then assert sram_data_r_en together with A's read pending → a_ack = 1 in that cycle; count remains 4.
- Spurious beat: after reset, pulse sram_data_r_en with no reads issued → a_data_r_en = b_data_r_en = 0, err = 1 from the next cycle and held.
- Reset mid-flight: 2 reads outstanding, assert reset for 1 cycle → sram_req = 0 and acks = 0 during reset; the FIFO is empty afterwards and prio = A; a late beat sets err.
